// File: rtl/comp_mult_res_chk.sv
// Result-side checker for the complex multiplier: snoops operands, queues expected products, sinks and checks results.
// Latency: expected entry poppable one edge after push; status/counters update one edge after each result handshake.
// Backpressure: res_rdy is registered en (gated by an LFSR when COMP_MULT_CHK_THROTTLE_EN is defined); a full queue drops new expectations and sets ovf.
module comp_mult_res_chk #(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       sw_rst,
  input  logic                       en,
  input  logic                       op_val,
  input  logic                       op_rdy,
  input  logic [4*DWIDTH-1:0]        op_data,
  input  logic                       res_val,
  output logic                       res_rdy,
  input  logic [4*(DWIDTH+1)-1:0]    res_data,
  output logic                       err,
  output logic [15:0]                match_cnt,
  output logic [15:0]                err_cnt,
  output logic                       ovf,
  output logic                       unexp,
  output logic [$clog2(DEPTH):0]     pending
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = 2*DWIDTH;        // product width
  localparam int RW = 2*DWIDTH + 2;    // result component width
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Operand unpacking, x1 in the MSBs
  logic signed [DWIDTH-1:0] x1, x2, y1, y2;
  assign x1 = op_data[4*DWIDTH-1 -: DWIDTH];
  assign x2 = op_data[3*DWIDTH-1 -: DWIDTH];
  assign y1 = op_data[2*DWIDTH-1 -: DWIDTH];
  assign y2 = op_data[DWIDTH-1   -: DWIDTH];

  // Signed products at full product width, then sign-extended before the add/sub
  logic signed [PW-1:0] p_x1x2, p_y1y2, p_x1y2, p_y1x2;
  logic signed [RW-1:0] exp_xr, exp_yr;
  logic [2*RW-1:0]      exp_word;

  assign p_x1x2   = PW'(x1) * PW'(x2);
  assign p_y1y2   = PW'(y1) * PW'(y2);
  assign p_x1y2   = PW'(x1) * PW'(y2);
  assign p_y1x2   = PW'(y1) * PW'(x2);
  assign exp_xr   = RW'(p_x1x2) - RW'(p_y1y2);
  assign exp_yr   = RW'(p_x1y2) + RW'(p_y1x2);
  assign exp_word = {exp_xr, exp_yr};

  // Expected-result queue storage and bookkeeping
  logic [2*RW-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count;

  logic push_req, pop_req, do_push, do_pop;
  logic empty, full, mismatch, bad_res;

  assign push_req = en & op_val & op_rdy;
  // A completed handshake is always checked: the multiplier has already let go of the result,
  // even in the single cycle where en has dropped but the registered res_rdy is still high.
  assign pop_req  = res_val & res_rdy;
  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign do_pop   = pop_req & ~empty;
  // A pop in the same cycle frees the slot, so a full queue can still accept the push.
  assign do_push  = push_req & (~full | do_pop);
  assign mismatch = (mem[rd_ptr] != res_data);
  assign bad_res  = pop_req & (empty | mismatch);

  // Queue write port; entries carry no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= exp_word;
    end
  end

  // Read/write pointers and occupancy counter
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Check outcome: error pulse, saturating counters and sticky flags
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      err       <= 1'b0;
      match_cnt <= '0;
      err_cnt   <= '0;
      ovf       <= 1'b0;
      unexp     <= 1'b0;
    end else begin
      err <= bad_res;
      if (do_pop && !mismatch && match_cnt != 16'hFFFF) match_cnt <= match_cnt + 16'd1;
      if (bad_res && err_cnt != 16'hFFFF)               err_cnt   <= err_cnt + 16'd1;
      if (pop_req && empty)                             unexp     <= 1'b1;
      if (push_req && full && !do_pop)                  ovf       <= 1'b1;
    end
  end

  assign pending = count;

`ifdef COMP_MULT_CHK_THROTTLE_EN
  // Fibonacci LFSR (taps 16,14,13,11) pseudo-randomly withholding res_rdy
  logic [15:0] lfsr;
  logic        lfsr_fb;
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  // LFSR state and throttled ready register
  always_ff @(posedge clk) begin
    if (sw_rst) begin
      lfsr    <= 16'hACE1;
      res_rdy <= 1'b0;
    end else begin
      if (en) lfsr <= {lfsr[14:0], lfsr_fb};
      res_rdy <= en & lfsr[0];
    end
  end
`else
  // Ready simply follows enable one cycle later
  always_ff @(posedge clk) begin
    if (sw_rst) res_rdy <= 1'b0;
    else        res_rdy <= en;
  end
`endif

endmodule
